// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the fetch stage and its prefetch FIFO.
package instr_fetch_pkg;

    typedef enum logic [1:0] {S_START, S_RUN, S_DRAIN, S_HALT} fetch_state_t;

    localparam logic [31:0] FETCH_PC_STEP = 32'd4;

    // Raw instruction word handed to decode.
    typedef logic [31:0] instr_packet;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO: registered storage, power-of-two depth, flush wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers words for decode.
// Optional FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_stall counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output instr_packet instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] owed_next;
    logic [CW:0]   in_use;
    logic          fault;

    logic [CW-1:0] fifo_count;
    instr_packet   fifo_head;
    logic          fifo_empty;
    logic          fifo_full;

    logic running;
    logic req_fire;
    logic pop_fire;
    logic resp_owed;
    logic redirect_hit;
    logic keep_resp;

    assign running      = (state == S_RUN) || (state == S_DRAIN);
    assign in_use       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req_fire     = imem_req_valid && imem_req_ready;
    assign pop_fire     = instr_valid && instr_ready;
    assign resp_owed    = imem_resp_valid && (outstanding != '0);
    assign redirect_hit = redirect_valid && (state != S_HALT);
    // Outstanding counts every owed response, wrong-path ones included, so the
    // issue limit bounds total in-flight traffic and never overflows the FIFO.
    assign owed_next    = outstanding - CW'(resp_owed) + CW'(req_fire);
    assign keep_resp    = resp_owed && (discard == '0) && running && !redirect_hit;

    assign imem_req_valid = running && !fifo_full && (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign instr_valid    = !fifo_empty;
    assign instr          = fifo_head;
    assign instr_pc       = head_pc;
    assign fetch_fault    = fault;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(instr_packet))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (keep_resp),
        .din   (imem_resp_data),
        .pop   (pop_fire && !redirect_hit),
        .flush (redirect_hit),
        .count (fifo_count),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_START;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fault       <= 1'b0;
        end else if (redirect_hit) begin
            if (!pc_aligned(redirect_target)) begin
                state       <= S_HALT;
                fault       <= 1'b1;
                outstanding <= '0;
                discard     <= '0;
            end else begin
                // Everything still owed, including this cycle's accept, is wrong-path.
                fetch_pc    <= redirect_target;
                head_pc     <= redirect_target;
                outstanding <= owed_next;
                discard     <= owed_next;
                state       <= (owed_next != '0) ? S_DRAIN : S_RUN;
            end
        end else begin
            case (state)
                S_START: state <= S_RUN;
                S_RUN, S_DRAIN: begin
                    if (req_fire) fetch_pc <= fetch_pc + FETCH_PC_STEP;
                    if (pop_fire) head_pc <= head_pc + FETCH_PC_STEP;
                    outstanding <= owed_next;
                    if (resp_owed && (discard != '0)) begin
                        discard <= discard - CW'(1);
                        if (discard == CW'(1)) state <= S_RUN;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop_fire) perf_fetched <= perf_fetched + 32'd1;
            if (running && !instr_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a PC-stream / memory-queue reference model.
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        fetch_fault;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clock = ~clock;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_COUNTERS_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    // stimulus knobs
    int p_ready = 100, p_ir = 100, p_redir = 0, lat_lo = 1, lat_hi = 1;
    bit coincide = 0;
    bit force_redir = 0;
    logic [31:0] force_tgt = '0;

    // reference model state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          edge_no = 0, last_due = 0;
    logic [31:0] exp_fetch, exp_pc, last_acc;
    bit          last_acc_v, halted, first_step, hold_pending;
    int          useful, n_pops, wrap_seen, m_fetched, m_stall;
    logic        last_rv, last_iv;

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        last_due     = edge_no;
        exp_fetch    = RPC;
        exp_pc       = RPC;
        last_acc_v   = 0;
        halted       = 0;
        first_step   = 1;
        hold_pending = 0;
        useful       = 0;
        m_fetched    = 0;
        m_stall      = 0;
    endtask

    task automatic clear_inputs();
        imem_req_ready  = 0;
        imem_resp_valid = 0;
        imem_resp_data  = '0;
        redirect_valid  = 0;
        redirect_target = '0;
        instr_ready     = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, RPC);
        chk("rst_fault", fetch_fault, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("start_no_req", imem_req_valid, 0);
        model_reset();
    endtask

    task automatic step();
        logic        rv, iv, acc, pop_ev, rd;
        logic [31:0] ra, ipc, ins, tgt;
        int          due;
        @(negedge clock);
        rv = imem_req_valid; ra = imem_req_addr;
        iv = instr_valid; ipc = instr_pc; ins = instr;
        last_rv = rv; last_iv = iv;
        if (halted) begin
            chk("halt_req_valid", rv, 0);
            chk("halt_instr_valid", iv, 0);
            chk("halt_fault", fetch_fault, 1);
        end else begin
            chk("fetch_fault", fetch_fault, 0);
            if (first_step) chk("first_req_valid", rv, 1);
            if (rv) chk("req_addr", ra, exp_fetch);
            if (hold_pending) chk("req_hold", rv, 1);
            if (iv) begin
                chk("instr_pc", ipc, exp_pc);
                chk("instr", ins, mem_word(exp_pc));
            end
        end
        first_step = 0;

        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        if (mq_due.size() > 0 && mq_due[0] <= edge_no) begin
            imem_resp_valid = 1;
            imem_resp_data  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 0;
            imem_resp_data  = $urandom;
        end
        instr_ready = ($urandom_range(0, 99) < p_ir);
        rd  = 0;
        tgt = $urandom;
        if (force_redir) begin
            rd = 1; tgt = force_tgt; force_redir = 0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            rd = 1; tgt = 32'($urandom_range(0, 1023)) << 2;
        end else if (coincide && imem_resp_valid && iv && instr_ready &&
                     $urandom_range(0, 99) < 40) begin
            rd = 1; tgt = 32'($urandom_range(0, 1023)) << 2;
        end
        redirect_valid  = rd;
        redirect_target = tgt;

        acc    = rv && imem_req_ready;
        pop_ev = iv && instr_ready;
        if (acc) begin
            due = edge_no + $urandom_range(lat_lo, lat_hi);
            if (due <= last_due) due = last_due + 1;
            mq_addr.push_back(ra);
            mq_due.push_back(due);
            last_due = due;
        end
        hold_pending = rv && !acc && !rd;
        if (!halted) begin
            if (pop_ev) m_fetched++;
            if (!iv) m_stall++;
            if (rd) begin
                last_acc_v = 0;
                if (tgt[1:0] != 2'b00) halted = 1;
                else begin
                    exp_fetch = tgt; exp_pc = tgt; useful = 0;
                end
            end else begin
                if (acc) begin
                    if (last_acc_v && last_acc == 32'hFFFF_FFFC) begin
                        chk("wrap_addr", ra, 32'h0);
                        wrap_seen++;
                    end
                    last_acc = ra; last_acc_v = 1;
                    exp_fetch += 32'd4;
                    useful++;
                    chk("inflight_bound", 32'(useful <= DEPTH), 1);
                end
                if (pop_ev) begin
                    exp_pc += 32'd4; useful--; n_pops++;
                end
            end
        end
        edge_no++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_COUNTERS_EN
        @(posedge clock);
        #1;
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_stall", perf_stall, 32'(m_stall));
`endif
    endtask

    initial begin
        clear_inputs();
        model_reset();
        n_pops = 0; wrap_seen = 0;
        #3;
        apply_reset();

        // steady streaming, latency 1
        run(20);
        chk("p1_progress", 32'(n_pops >= 5), 1);

        // decode stalled: issue must stop once the FIFO budget is used
        p_ir = 0;
        run(10);
        chk("stall_req_drop", last_rv, 0);
        chk("stall_buffered", last_iv, 1);
        p_ir = 100;
        n_pops = 0;
        run(10);
        chk("stall_resume", 32'(n_pops >= 3), 1);

        // redirects against latency-3 memory
        lat_lo = 3; lat_hi = 3; p_ir = 70; p_redir = 15;
        run(200);

        // redirect coinciding with response and pop
        lat_lo = 1; lat_hi = 1; p_ir = 100; p_redir = 0; coincide = 1;
        run(100);
        coincide = 0;

        // mixed random traffic
        p_ready = 60; lat_lo = 1; lat_hi = 4; p_ir = 60; p_redir = 5;
        n_pops = 0;
        run(1500);
        chk("rand_progress", 32'(n_pops >= 100), 1);

        // PC wrap
        p_ready = 100; lat_lo = 1; lat_hi = 2; p_ir = 100; p_redir = 0;
        force_tgt = 32'hFFFF_FFF8; force_redir = 1;
        run(30);
        chk("wrap_seen", 32'(wrap_seen > 0), 1);
        check_perf();

        // misaligned redirect halts; aligned redirect in halt is ignored
        force_tgt = 32'h0000_0102; force_redir = 1;
        run(8);
        force_tgt = 32'h0000_0200; force_redir = 1;
        run(8);
        check_perf();

        // asynchronous reset mid-cycle clears the fault and restarts
        @(negedge clock);
        #2;
        apply_reset();
        n_pops = 0;
        run(30);
        chk("restart_progress", 32'(n_pops >= 5), 1);
        check_perf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
